// File: rtl/req_ack_responder_if.sv
// req_ack_responder_if: req/ack handshake bundle between an initiator (master) and the responder (slave).
interface req_ack_responder_if #(
    parameter int DATA_W = 8,
    parameter int LAT_W  = 3,
    parameter int CNT_W  = 16
);
    logic              req;
    logic [DATA_W-1:0] req_data;
    logic [LAT_W-1:0]  cfg_lat;
    logic              ack;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic              proto_err;
    logic [CNT_W-1:0]  txn_cnt;
    modport master (output req, req_data, cfg_lat, input ack, rsp_data, busy, proto_err, txn_cnt);
    modport slave  (input req, req_data, cfg_lat, output ack, rsp_data, busy, proto_err, txn_cnt);
endinterface

// File: rtl/req_ack_responder.sv
// req_ack_responder: acks each request after cfg_lat cycles with req_data+1, flags protocol errors, counts acks.
// Define REQ_ACK_RESP_SVA_EN to compile in the handshake assertions.
module req_ack_responder #(
    parameter int DATA_W = 8,
    parameter int LAT_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    req_ack_responder_if.slave bus
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rsp_q, rsp_d, inc;
    logic [CNT_W-1:0]  txn_q, txn_d;
    logic              err_q, err_d;
    logic              idle, ack;
    assign idle = state_q == S_IDLE;
    assign inc  = bus.req_data + 1'b1;
    // ack is combinational so that a zero-latency request completes in its own cycle
    assign ack  = !rst && bus.req && (idle ? bus.cfg_lat == '0 : cnt_q == '0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rsp_q   <= '0;
            txn_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
            txn_q   <= txn_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rsp_d   = rsp_q;
        err_d   = err_q;
        txn_d   = ack ? txn_q + 1'b1 : txn_q;
        if (idle) begin
            if (bus.req && bus.cfg_lat != '0) begin
                state_d = S_WAIT;
                cnt_d   = bus.cfg_lat - 1'b1;
                rsp_d   = inc;
            end
        end else begin
            // rsp_q holds the accepted data plus one, so any change of req_data shows as a mismatch
            err_d   = err_q || !bus.req || inc != rsp_q;
            state_d = (!bus.req || cnt_q == '0) ? S_IDLE : S_WAIT;
            cnt_d   = cnt_q == '0 ? '0 : cnt_q - 1'b1;
        end
    end
    always_comb begin
        bus.ack       = ack;
        bus.rsp_data  = !ack ? '0 : idle ? inc : rsp_q;
        bus.busy      = !idle;
        bus.proto_err = err_q;
        bus.txn_cnt   = txn_q;
    end
`ifdef REQ_ACK_RESP_SVA_EN
    a_ack_req: assert property (@(posedge clk) disable iff (rst) bus.ack |-> bus.req);
    a_lat0:    assert property (@(posedge clk) disable iff (rst) idle && bus.req && bus.cfg_lat == '0 |-> bus.ack);
    a_lat1:    assert property (@(posedge clk) disable iff (rst) idle && bus.req && bus.cfg_lat == LAT_W'(1) |=> bus.ack || !bus.req);
    a_pulse:   assert property (@(posedge clk) disable iff (rst) bus.ack |=> !bus.ack || bus.req);
    a_err:     assert property (@(posedge clk) disable iff (rst) $rose(bus.proto_err) |-> $past(!idle && (!bus.req || inc != rsp_q)));
`endif
endmodule

// File: tb/tb_req_ack_responder.sv
// tb_req_ack_responder: randomized and directed stimulus, expected acks queued per request and checked by a monitor.
module tb_req_ack_responder;
    localparam int DATA_W = 8;
    localparam int LAT_W  = 3;
    localparam int CNT_W  = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    req_ack_responder_if #(.DATA_W(DATA_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) bus ();
    req_ack_responder #(.DATA_W(DATA_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        int          cyc;
        logic [7:0]  data;
        logic [15:0] cnt;
    } exp_t;
    exp_t        q[$];
    exp_t        e;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] txn_exp = '0;
    bit          exp_err = 1'b0;
    int          busy_lo = 1;
    int          busy_hi = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask
    // monitor: one expected entry per ack, timing, payload and pre-ack count all checked
    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
            check("proto_err", 32'(bus.proto_err), 32'(exp_err));
            if (bus.ack) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ack: got ack with rsp 0x%0h, expected no ack (cycle %0d)", bus.rsp_data, cyc);
                end else begin
                    e = q.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    check("txn_cnt_at_ack", 32'(bus.txn_cnt), 32'(e.cnt));
                end
            end else begin
                check("rsp_idle", 32'(bus.rsp_data), 32'd0);
                if (q.size() != 0 && q[0].cyc <= cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL missing_ack: got no ack, expected ack with 0x%0h at cycle %0d", q[0].data, q[0].cyc);
                    void'(q.pop_front());
                end
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic txn(input logic [7:0] d, input int lat, input int new_lat, input bit hold);
        int         t;
        logic [7:0] r;
        t = cyc;
        r = d + 8'd1;
        bus.req = 1'b1;
        bus.req_data = d;
        bus.cfg_lat = LAT_W'(lat);
        q.push_back('{t + lat, r, txn_exp});
        txn_exp++;
        if (lat > 0) begin
            busy_lo = t + 1;
            busy_hi = t + lat;
        end
        step();
        bus.cfg_lat = LAT_W'(new_lat);
        repeat (lat) step();
        if (!hold) begin
            bus.req = 1'b0;
            step();
        end
    endtask
    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end
    initial begin
        int t;
        int n;
        bus.req = 1'b0;
        bus.req_data = '0;
        bus.cfg_lat = '0;
        #1;
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_rsp", 32'(bus.rsp_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.proto_err), 32'd0);
        check("rst_cnt", 32'(bus.txn_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        txn(8'h10, 0, 0, 1'b0);
        check("txn_cnt_after_first", 32'(bus.txn_cnt), 32'(txn_exp));
        txn(8'hFF, 1, 1, 1'b0);
        txn(8'h3C, 5, 2, 1'b1);
        txn(8'h77, 2, 2, 1'b0);
        check("txn_cnt_directed", 32'(bus.txn_cnt), 32'(txn_exp));
        repeat (300) begin
            bit h;
            h = 1'($urandom_range(0, 1));
            txn(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), h);
            if (!h) repeat ($urandom_range(0, 2)) step();
        end
        bus.req = 1'b0;
        step();
        check("txn_cnt_random", 32'(bus.txn_cnt), 32'(txn_exp));
        t = cyc;
        bus.req = 1'b1;
        bus.req_data = 8'hA5;
        bus.cfg_lat = 3'd4;
        busy_lo = t + 1;
        busy_hi = t + 2;
        step();
        step();
        bus.req = 1'b0;
        step();
        exp_err = 1'b1;
        repeat (6) step();
        check("err_txn_cnt", 32'(bus.txn_cnt), 32'(txn_exp));
        t = cyc;
        bus.req = 1'b1;
        bus.req_data = 8'h5E;
        bus.cfg_lat = 3'd6;
        q.push_back('{t + 6, 8'h5F, txn_exp});
        busy_lo = t + 1;
        busy_hi = t + 2;
        repeat (3) step();
        rst = 1'b1;
        bus.req = 1'b0;
        #1;
        check("midrst_ack", 32'(bus.ack), 32'd0);
        check("midrst_rsp", 32'(bus.rsp_data), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_err", 32'(bus.proto_err), 32'd0);
        check("midrst_cnt", 32'(bus.txn_cnt), 32'd0);
        q.delete();
        txn_exp = '0;
        exp_err = 1'b0;
        busy_hi = 0;
        repeat (2) step();
        rst = 1'b0;
        repeat (10) step();
        txn(8'h42, 2, 2, 1'b0);
        check("cnt_after_reset_txn", 32'(bus.txn_cnt), 32'd1);
        t = cyc;
        bus.req = 1'b1;
        bus.req_data = 8'h21;
        bus.cfg_lat = 3'd3;
        q.push_back('{t + 3, 8'h22, txn_exp});
        txn_exp++;
        busy_lo = t + 1;
        busy_hi = t + 3;
        step();
        bus.req_data = 8'h21 ^ 8'h5A;
        step();
        exp_err = 1'b1;
        repeat (2) step();
        bus.req = 1'b0;
        step();
        n = 65535 - int'(txn_exp);
        for (int i = 0; i < n; i++) txn(8'($urandom), 0, 0, 1'b1);
        check("cnt_all_ones", 32'(bus.txn_cnt), 32'hFFFF);
        txn(8'h00, 0, 0, 1'b0);
        check("cnt_wrap", 32'(bus.txn_cnt), 32'(txn_exp));
        repeat (3) step();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/req_ack_responder.md
# req_ack_responder

Responder side of the single-cycle-pulse req/ack handshake used by the SVA lessons. Accepts a request from an initiator, waits a programmable number of cycles, then returns a one-cycle `ack` with response data. It is the DUT the overlapping (`|->`) and non-overlapping (`|=>`) implication checks are written against. It also flags initiator protocol violations and counts completed transactions.

## Interface
- `DATA_W`, 8, payload width of request and response.
- `LAT_W`, 3, width of the latency setting; maximum latency is 2^LAT_W−1 cycles.
- `CNT_W`, 16, width of the transaction counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  request from the initiator; level, held until `ack`.
- `req_data`  in  DATA_W  request payload, stable while `req` is high.
- `cfg_lat`  in  LAT_W  ack latency in cycles; sampled when a request is accepted.
- `ack`  out  1  one-cycle acknowledge pulse.
- `rsp_data`  out  DATA_W  response payload, valid only while `ack` is high.
- `busy`  out  1  a request is accepted and not yet acknowledged.
- `proto_err`  out  1  sticky flag for an initiator violation; cleared only by `rst`.
- `txn_cnt`  out  CNT_W  count of completed acks; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, WAIT.
- IDLE, `req`=1, `cfg_lat`=0:
  - `ack`=1 in the same cycle, driven combinationally from `req` & IDLE.
  - `rsp_data` = `req_data`+1 (mod 2^DATA_W).
  - Stay in IDLE.
- IDLE, `req`=1, `cfg_lat`=L≥1:
  - Latch `req_data`+1 into the response register.
  - Load the down-counter with L−1 and go to WAIT. `busy`=1.
- WAIT:
  - When the counter is 0: `ack`=1 and `rsp_data` = the latched value; return to IDLE.
  - Otherwise decrement the counter.
- After an ack, a `req` still high in the next cycle is a new request (back-to-back is allowed). The initiator drops `req` in the cycle after `ack` if it has no further request.
- Protocol errors:
  - `req` falls while in WAIT sets `proto_err`=1. The FSM returns to IDLE next edge, no ack is issued, and `txn_cnt` is unchanged.
  - `req_data` changes while in WAIT sets `proto_err`. The transaction still completes with the originally latched data.
- `txn_cnt` increments on every cycle with `ack`=1.
- `cfg_lat` changes during WAIT have no effect on the pending request.

## Timing
- Reset values: `ack`=0, `rsp_data`=0, `busy`=0, `proto_err`=0, `txn_cnt`=0; FSM in IDLE, counter 0.
- Latency from the first `req`-high cycle t to `ack` is exactly t+L.
  - L=0 satisfies `req |-> ack`.
  - L=1 satisfies `req |=> ack` for an isolated request.
- `ack` is never high for more than one consecutive cycle, except L=0 with `req` held, where every cycle is a new transaction.
- `ack` is never high while `req` is low in the same cycle.
- `rsp_data` is 0 whenever `ack`=0.
- Reset asserted mid-transaction: all outputs return to their reset values immediately, the pending request is discarded, and no ack is issued afterwards.
- First request after `rst` deasserts is accepted on the first rising edge with `req`=1.
- `txn_cnt` at all ones, followed by an ack, gives 0.

## Configuration
- `REQ_ACK_RESP_SVA_EN` defined: the module compiles in concurrent assertions, clocked on `clk` and disabled iff `rst`:
  - ack implies req (`ack |-> req`).
  - L=0 accepted gives ack the same cycle (`|->`).
  - L=1 accepted gives ack the next cycle (`|=>`).
  - `ack |=> !ack || req`.
  - `$rose(proto_err)` implies the previous-cycle req drop or data change.
- `REQ_ACK_RESP_SVA_EN` undefined: no assertions are compiled. RTL behaviour, including `proto_err`, is identical in both builds.

## Test plan
- Reset, then `cfg_lat`=0, `req`=1 with `req_data`=0x10 for one cycle → `ack`=1 the same cycle, `rsp_data`=0x11, `txn_cnt`=1.
- `cfg_lat`=1, `req` high with data 0xFF until ack → `ack` exactly one cycle later, `rsp_data`=0x00, `busy`=1 for one cycle.
- `cfg_lat`=5, `req` held with data 0x3C, `cfg_lat` changed to 2 after acceptance → `ack` at t+5 with 0x3D; then `req` held for a second request → second `ack` at that acceptance +2.
- `cfg_lat`=4, `req` dropped at t+2 → `proto_err`=1 from t+3 onward, no `ack`, `txn_cnt` unchanged, FSM in IDLE.
- `cfg_lat`=6, `rst` pulsed at t+3 → all outputs 0 immediately, no `ack` ever; a fresh request after reset completes normally.
- Preload `txn_cnt` to 0xFFFF via 65535 L=0 acks, then one more ack → `txn_cnt`=0.
